// File: rtl/fp32_pkg.sv
// Shared binary32 helpers: constants, NaN test, total-order key and argmax FSM states.
package fp32_pkg;

    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} argmax_state_e;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] canon_zero(input logic [31:0] v);
        return (v == FP32_NEG_ZERO) ? FP32_POS_ZERO : v;
    endfunction

    // Unsigned key whose integer order matches the numeric order of non-NaN values.
    function automatic logic [31:0] order_key(input logic [31:0] v);
        logic [31:0] c;
        c = canon_zero(v);
        return c[31] ? ~c : {1'b1, c[30:0]};
    endfunction

endpackage

// File: rtl/fp32_order_key.sv
// Combinational binary32 -> order key, NaN flag and zero-canonicalised value.
module fp32_order_key
    import fp32_pkg::*;
(
    input  logic [31:0] data,
    output logic [31:0] key,
    output logic        nan,
    output logic [31:0] canon
);

    assign key   = order_key(data);
    assign nan   = is_nan(data);
    assign canon = canon_zero(data);

endmodule

// File: rtl/fp32_argmax_classifier.sv
// Streams binary32 class scores, returns index and value of the maximum per frame.
//
// state | meaning
// IDLE  | armed, nothing accumulated; next accepted beat is index 0
// ACCUM | mid-frame, tracking best key and beat count
// HOLD  | result presented on outputs until out_ready
module fp32_argmax_classifier
    import fp32_pkg::*;
#(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_class,
    output logic [31:0]      out_prob,
    output logic             frame_err
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    argmax_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [31:0]      best_key_q, best_key_d;
    logic [31:0]      best_val_q, best_val_d;
    logic             have_best_q, have_best_d;
    logic             nan_seen_q, nan_seen_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_class_q, out_class_d;
    logic [31:0]      out_prob_q, out_prob_d;
    logic             frame_err_q, frame_err_d;

    logic [31:0] beat_key;
    logic [31:0] beat_val;
    logic        beat_nan;
    logic        take, nan_any, at_last;

    fp32_order_key u_key (
        .data  (in_data),
        .key   (beat_key),
        .nan   (beat_nan),
        .canon (beat_val)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_idx_d  = best_idx_q;
        best_key_d  = best_key_q;
        best_val_d  = best_val_q;
        have_best_d = have_best_q;
        nan_seen_d  = nan_seen_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_prob_d  = out_prob_q;
        frame_err_d = frame_err_q;

        // Strict compare keeps the earliest index on ties.
        take    = !beat_nan && (!have_best_q || (beat_key > best_key_q));
        nan_any = nan_seen_q || beat_nan;
        at_last = (cnt_q == LAST_IDX);

        case (state_q)
            IDLE, ACCUM: begin
                if (in_valid) begin
                    if (in_last || at_last) begin
                        state_d     = HOLD;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_class_d = take ? cnt_q[IDX_W-1:0] : best_idx_q;
                        out_prob_d  = take ? beat_val
                                           : (have_best_q ? best_val_q : FP32_QNAN);
                        // Mismatch covers both short (early last) and long (missing last).
                        frame_err_d = nan_any || (in_last != at_last);
                        cnt_d       = '0;
                        best_idx_d  = '0;
                        have_best_d = 1'b0;
                        nan_seen_d  = 1'b0;
                    end else begin
                        state_d    = ACCUM;
                        cnt_d      = cnt_q + 1'b1;
                        nan_seen_d = nan_any;
                        if (take) begin
                            best_idx_d  = cnt_q[IDX_W-1:0];
                            best_key_d  = beat_key;
                            best_val_d  = beat_val;
                            have_best_d = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            best_idx_q  <= '0;
            best_key_q  <= '0;
            best_val_q  <= '0;
            have_best_q <= 1'b0;
            nan_seen_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_prob_q  <= FP32_POS_ZERO;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_idx_q  <= best_idx_d;
            best_key_q  <= best_key_d;
            best_val_q  <= best_val_d;
            have_best_q <= have_best_d;
            nan_seen_q  <= nan_seen_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_prob_q  <= out_prob_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_prob  = out_prob_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fp32_argmax_classifier.sv
// Bench for fp32_argmax_classifier: frame-level argmax model, directed plan cases, random traffic.
module tb_fp32_argmax_classifier;

    localparam int N     = 10;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = 32'h0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDX_W-1:0] out_class;
    logic [31:0]      out_prob;
    logic             frame_err;

    int tests = 0;
    int fails = 0;

    fp32_argmax_classifier #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_prob  (out_prob),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 0);
    endfunction

    function automatic logic [31:0] m_canon(input logic [31:0] v);
        return (v == 32'h8000_0000) ? 32'h0 : v;
    endfunction

    // Numeric a > b for canonical non-NaN values, sign/magnitude reasoning.
    function automatic bit m_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    logic [31:0]      frame_q[$];
    bit               m_hold = 0;
    logic [IDX_W-1:0] m_class = '0;
    logic [31:0]      m_prob = 32'h0;
    bit               m_err = 0;

    function automatic void m_close(input bit last);
        int best;
        best  = -1;
        m_err = !(frame_q.size() == N && last);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (m_nan(frame_q[i])) m_err = 1;
            else if (best < 0 || m_gt(m_canon(frame_q[i]), m_canon(frame_q[best]))) best = i;
        end
        m_class = (best < 0) ? '0 : IDX_W'(best);
        m_prob  = (best < 0) ? 32'h7FC0_0000 : m_canon(frame_q[best]);
        m_hold  = 1;
        frame_q.delete();
    endfunction

    always begin
        @(posedge clk);
        if (rst) begin
            frame_q.delete();
            m_hold = 0; m_class = '0; m_prob = 32'h0; m_err = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            frame_q.push_back(in_data);
            if (in_last || frame_q.size() == N) m_close(in_last);
        end
        #1;
        chk("in_ready",  {31'b0, in_ready},  {31'b0, !m_hold});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_hold});
        chk("out_class", {28'b0, out_class}, {28'b0, m_class});
        chk("out_prob",  out_prob, m_prob);
        chk("frame_err", {31'b0, frame_err}, {31'b0, m_err});
    end

    // ---------------- directed helpers ----------------
    task automatic beat(input logic [31:0] d, input bit l);
        in_valid = 1; in_data = d; in_last = l;
        @(negedge clk);
        in_valid = 0; in_last = 0; in_data = 32'h0;
    endtask

    task automatic result(input string nm, input int c, input logic [31:0] p, input bit e);
        chk({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({nm, "_class"}, {28'b0, out_class}, c);
        chk({nm, "_prob"},  out_prob, p);
        chk({nm, "_err"},   {31'b0, frame_err}, {31'b0, e});
    endtask

    task automatic release_out();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("release_valid", {31'b0, out_valid}, 32'd0);
        chk("release_ready", {31'b0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] specials [10];
        specials = '{32'h0, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                     32'h0000_0001, 32'h8000_0001, 32'h3F80_0000, 32'hBF80_0000, 32'h7F80_0001};
        case ($urandom % 8)
            0: return specials[$urandom % 10];
            1: return $urandom;
            default: return {1'($urandom), 8'(8'h78 + $urandom % 4), 3'($urandom % 4), 20'h0};
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_prob",  out_prob, 32'h0);
        rst = 0;
        @(negedge clk);

        chk("model_gt_pos",  {31'b0, m_gt(32'h3F68F5C3, 32'h3C23D70A)}, 32'd1);
        chk("model_gt_neg",  {31'b0, m_gt(32'hC0000000, 32'hBF800000)}, 32'd0);
        chk("model_gt_zero", {31'b0, m_gt(32'h0, m_canon(32'h8000_0000))}, 32'd0);

        for (int i = 0; i < 10; i++) beat(i == 7 ? 32'h3F68F5C3 : 32'h3C23D70A, i == 9);
        result("plan1", 7, 32'h3F68F5C3, 0);
        release_out();

        for (int i = 0; i < 10; i++)
            beat(i == 2 ? 32'h8000_0000 : (i == 5 ? 32'h0 : 32'hBF80_0000), i == 9);
        result("tie_zero", 2, 32'h0, 0);
        release_out();

        for (int i = 0; i < 4; i++) beat(i == 1 ? 32'h3F00_0000 : 32'h3E00_0000, i == 3);
        result("short", 1, 32'h3F00_0000, 1);
        release_out();

        for (int i = 0; i < 10; i++) beat(i == 6 ? 32'h4040_0000 : 32'h3F80_0000, 0);
        result("long", 6, 32'h4040_0000, 1);
        release_out();
        beat(32'hC000_0000, 0);
        beat(32'hBF80_0000, 1);
        result("long_tail", 1, 32'hBF80_0000, 1);
        release_out();

        for (int i = 0; i < 10; i++)
            beat(i == 0 ? 32'h7FC0_0000 : (i == 4 ? 32'h3E80_0000 : 32'h3D80_0000), i == 9);
        result("nan_one", 4, 32'h3E80_0000, 1);
        release_out();
        for (int i = 0; i < 10; i++) beat(i[0] ? 32'hFFC0_0001 : 32'h7F80_0001, i == 9);
        result("nan_all", 0, 32'h7FC0_0000, 1);
        release_out();

        for (int i = 0; i < 10; i++) beat(i == 3 ? 32'h7F80_0000 : 32'h42C8_0000, i == 9);
        in_valid = 1; in_data = 32'h7F7F_FFFF; in_last = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_ready", {31'b0, in_ready}, 32'd0);
            result("hold", 3, 32'h7F80_0000, 0);
        end
        in_valid = 0; in_last = 0;
        release_out();
        for (int i = 0; i < 10; i++) beat(32'h3F80_0000 + i, i == 9);
        result("after_hold", 9, 32'h3F80_0009, 0);
        release_out();

        for (int i = 0; i < 4; i++) beat(i == 0 ? 32'h7F7F_FFFF : 32'h3F80_0000, 0);
        rst = 1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_class", {28'b0, out_class}, 32'd0);
        chk("mid_rst_prob",  out_prob, 32'h0);
        chk("mid_rst_err",   {31'b0, frame_err}, 32'd0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 10; i++) beat(i == 5 ? 32'h3F00_0000 : 32'h3E00_0000, i == 9);
        result("post_rst", 5, 32'h3F00_0000, 0);
        release_out();

        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = rand_val();
            in_last   = ($urandom % 8) == 0;
            out_ready = ($urandom % 3) == 0;
            rst       = ($urandom % 700) == 0;
            @(negedge clk);
        end
        rst = 0; in_valid = 0; in_last = 0; out_ready = 1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
